digitron_display_unit: RTL and testbench

Front-panel timing and numeric display block. It divides the 50 MHz system clock into 100 kHz and 1 kHz tick enables and keeps millisecond and 10 ms uptime counters. It also holds a 6-digit user-edited decimal value driven by debounced key pulses, and scans it onto a multiplexed 6-digit seven-segment display. It sits between the key debouncer and the LCD/DAC consumers, which read its ticks, time counters and the binary value.

---
 rtl/digitron_pkg.sv | 37 +++
 rtl/digitron_display_unit_seg7_decode.sv | 15 +
 rtl/digitron_display_unit.sv | 171 +++++++++++++++++
 tb/tb_digitron_display_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/digitron_pkg.sv
// Shared constants for the digitron display unit: key indices, segment ROM,
// digit count and the BCD-to-binary helper.
package digitron_pkg;

  localparam int DIGITS = 6;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ENTER = 4;

  // Active-low gfedcba patterns with dp off; entry 0 sits in the low byte.
  localparam logic [9:0][7:0] SEG_ROM = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_ENTER
  } key_act_t;

  typedef logic [DIGITS-1:0][3:0] bcd_t;

  function automatic logic [19:0] bcd_to_bin(input bcd_t d);
    logic [19:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      acc = acc * 20'd10 + {16'd0, d[i]};
    return acc;
  endfunction

endpackage

// File: rtl/digitron_display_unit_seg7_decode.sv
// Combinational BCD to active-low seven-segment converter (segments only,
// the decimal point is merged by the caller). Non-decimal codes blank.
module seg7_decode
  import digitron_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    if (i_bcd <= 4'd9) o_seg = SEG_ROM[i_bcd][6:0];
  end

endmodule

// File: rtl/digitron_display_unit.sv
// Front-panel tick divider, uptime counters, 6-digit BCD editor and
// multiplexed seven-segment scan. Cursor blinking is built only when
// DIGITRON_BLINK_EN is defined.
module digitron_display_unit
  import digitron_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FAST_HZ     = 100_000,
  parameter int SLOW_HZ     = 1_000,
  parameter int BLINK_TICKS = 250
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [4:0]        i_key_pulse,
  output logic              o_tick_fast,
  output logic              o_tick_slow,
  output logic [31:0]       o_time_ms,
  output logic [31:0]       o_time_10ms,
  output logic [19:0]       o_number,
  output logic [DIGITS-1:0] o_cursor_pos,
  output logic [DIGITS-1:0] o_point_pos,
  output logic [7:0]        o_dig,
  output logic [DIGITS-1:0] o_sel
);

  localparam int FAST_DIV = CLK_HZ / FAST_HZ;
  localparam int SLOW_DIV = FAST_HZ / SLOW_HZ;
  localparam int FW = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam int SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  logic [FW-1:0]     r_fast_cnt;
  logic [SW-1:0]     r_slow_cnt;
  logic [3:0]        r_dec_cnt;
  logic              r_tick_fast, r_tick_slow;
  logic [31:0]       r_time_ms, r_time_10ms;
  bcd_t              r_digits;
  logic [DIGITS-1:0] r_cursor, r_point;
  logic [19:0]       r_number;
  logic [2:0]        r_scan_idx;
  logic [DIGITS-1:0] r_sel;
  logic [7:0]        r_dig;

  logic              w_fast_wrap, w_slow_wrap;
  key_act_t          w_act;
  logic [DIGITS-1:0] w_sel_oh;
  logic [3:0]        w_scan_bcd;
  logic [6:0]        w_seg, w_seg_shown;

  assign w_fast_wrap = (r_fast_cnt == FW'(FAST_DIV - 1));
  assign w_slow_wrap = w_fast_wrap && (r_slow_cnt == SW'(SLOW_DIV - 1));

  // Tick pulses are registered, so they appear the cycle after the wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fast_cnt  <= '0;
      r_slow_cnt  <= '0;
      r_dec_cnt   <= '0;
      r_tick_fast <= 1'b0;
      r_tick_slow <= 1'b0;
      r_time_ms   <= '0;
      r_time_10ms <= '0;
    end else begin
      r_fast_cnt  <= w_fast_wrap ? '0 : r_fast_cnt + FW'(1);
      r_tick_fast <= w_fast_wrap;
      r_tick_slow <= w_slow_wrap;
      if (w_fast_wrap) r_slow_cnt <= w_slow_wrap ? '0 : r_slow_cnt + SW'(1);
      if (w_slow_wrap) begin
        r_time_ms <= r_time_ms + 32'd1;
        r_dec_cnt <= (r_dec_cnt == 4'd9) ? 4'd0 : r_dec_cnt + 4'd1;
        if (r_dec_cnt == 4'd9) r_time_10ms <= r_time_10ms + 32'd1;
      end
    end
  end

  always_comb begin
    w_act = ACT_NONE;
    if      (i_key_pulse[KEY_UP])    w_act = ACT_UP;
    else if (i_key_pulse[KEY_DOWN])  w_act = ACT_DOWN;
    else if (i_key_pulse[KEY_LEFT])  w_act = ACT_LEFT;
    else if (i_key_pulse[KEY_RIGHT]) w_act = ACT_RIGHT;
    else if (i_key_pulse[KEY_ENTER]) w_act = ACT_ENTER;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digits <= '0;
      r_cursor <= DIGITS'(1);
      r_point  <= '0;
      r_number <= '0;
    end else begin
      r_number <= bcd_to_bin(r_digits);
      case (w_act)
        ACT_UP:
          for (int i = 0; i < DIGITS; i++)
            if (r_cursor[i]) r_digits[i] <= (r_digits[i] == 4'd9) ? 4'd0 : r_digits[i] + 4'd1;
        ACT_DOWN:
          for (int i = 0; i < DIGITS; i++)
            if (r_cursor[i]) r_digits[i] <= (r_digits[i] == 4'd0) ? 4'd9 : r_digits[i] - 4'd1;
        ACT_LEFT:  r_cursor <= {r_cursor[DIGITS-2:0], r_cursor[DIGITS-1]};
        ACT_RIGHT: r_cursor <= {r_cursor[0], r_cursor[DIGITS-1:1]};
        ACT_ENTER: r_point  <= (r_point == r_cursor) ? '0 : r_cursor;
        default: ;
      endcase
    end
  end

  assign w_sel_oh = DIGITS'(1) << r_scan_idx;

  always_comb begin
    w_scan_bcd = '0;
    for (int i = 0; i < DIGITS; i++)
      if (r_scan_idx == 3'(i)) w_scan_bcd = r_digits[i];
  end

  seg7_decode u_seg7_decode (
    .i_bcd (w_scan_bcd),
    .o_seg (w_seg)
  );

`ifdef DIGITRON_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_hidden;

  // A key press always wins over a phase toggle on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blink_cnt    <= '0;
      r_blink_hidden <= 1'b0;
    end else if (|i_key_pulse) begin
      r_blink_cnt    <= '0;
      r_blink_hidden <= 1'b0;
    end else if (w_slow_wrap) begin
      if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
        r_blink_cnt    <= '0;
        r_blink_hidden <= ~r_blink_hidden;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign w_seg_shown = (r_blink_hidden && |(r_cursor & w_sel_oh)) ? 7'h7F : w_seg;
`else
  assign w_seg_shown = w_seg;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan_idx <= '0;
      r_sel      <= '1;
      r_dig      <= 8'hFF;
    end else if (w_slow_wrap) begin
      r_sel      <= ~w_sel_oh;
      r_dig      <= {~|(r_point & w_sel_oh), w_seg_shown};
      r_scan_idx <= (r_scan_idx == 3'(DIGITS - 1)) ? 3'd0 : r_scan_idx + 3'd1;
    end
  end

  assign o_tick_fast  = r_tick_fast;
  assign o_tick_slow  = r_tick_slow;
  assign o_time_ms    = r_time_ms;
  assign o_time_10ms  = r_time_10ms;
  assign o_number     = r_number;
  assign o_cursor_pos = r_cursor;
  assign o_point_pos  = r_point;
  assign o_dig        = r_dig;
  assign o_sel        = r_sel;

endmodule

// File: tb/tb_digitron_display_unit.sv
// Directed bench for digitron_display_unit at a scaled-down clock
// (10 cycles per fast tick, 100 per slow tick).
module tb_digitron_display_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  key = '0;
  logic        tick_fast, tick_slow;
  logic [31:0] time_ms, time_10ms;
  logic [19:0] number;
  logic [5:0]  cursor_pos, point_pos, sel;
  logic [7:0]  dig;

  int tests = 0;
  int fails = 0;
  bit ok;

  digitron_display_unit #(
    .CLK_HZ(1000), .FAST_HZ(100), .SLOW_HZ(10), .BLINK_TICKS(2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_pulse  (key),
    .o_tick_fast  (tick_fast),
    .o_tick_slow  (tick_slow),
    .o_time_ms    (time_ms),
    .o_time_10ms  (time_10ms),
    .o_number     (number),
    .o_cursor_pos (cursor_pos),
    .o_point_pos  (point_pos),
    .o_dig        (dig),
    .o_sel        (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [4:0] k);
    key = k;
    @(posedge clk); #1;
    key = '0;
  endtask

  // Cycle c (1-based from reset release) must carry tick_fast iff c%10==0
  // and tick_slow iff c%100==0.
  task automatic check_ticks(input int n);
    int ef = 0, es = 0;
    for (int c = 1; c <= n; c++) begin
      step();
      if (tick_fast !== (c % 10 == 0)) ef++;
      if (tick_slow !== (c % 100 == 0)) es++;
    end
    chk("tick_fast cadence errors", ef, 0);
    chk("tick_slow cadence errors", es, 0);
  endtask

  task automatic wait_tick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (tick_slow === 1'b1) found = 1'b1;
    end
  endtask

  task automatic wait_sel(input logic [5:0] target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 800 && !found; i++) begin
      step();
      if (tick_slow === 1'b1 && sel === target) found = 1'b1;
    end
  endtask

  initial begin
    #12;
    chk("reset tick_fast", tick_fast, 0);
    chk("reset tick_slow", tick_slow, 0);
    chk("reset time_ms", time_ms, 0);
    chk("reset time_10ms", time_10ms, 0);
    chk("reset number", number, 0);
    chk("reset cursor", cursor_pos, 6'h01);
    chk("reset point", point_pos, 6'h00);
    chk("reset sel", sel, 6'h3F);
    chk("reset dig", dig, 8'hFF);
    #10 rst = 1'b0;

    // Divider and time counters over 10 slow ticks.
    check_ticks(1000);
    chk("time_ms after 1000", time_ms, 10);
    chk("time_10ms after 1000", time_10ms, 1);
    chk("sel at 10th tick", sel, 6'h37);
    chk("dig at 10th tick", dig, 8'hC0);

    // Digit edit, number latency and wrap.
    press(5'b00001); press(5'b00001); press(5'b00001);
    chk("number one cycle late", number, 2);
    step();
    chk("number 3xUP", number, 3);
    press(5'b00100);
    chk("cursor LEFT", cursor_pos, 6'h02);
    press(5'b00010);
    step();
    chk("number DOWN wrap", number, 93);

    // Cursor wrap both directions.
    press(5'b01000);
    press(5'b01000);
    chk("cursor RIGHT wrap", cursor_pos, 6'h20);
    press(5'b00100);
    chk("cursor LEFT wrap", cursor_pos, 6'h01);

    // Key priority.
    press(5'b00011);
    step();
    chk("UP beats DOWN", number, 94);
    press(5'b11101);
    chk("UP beats LEFT/RIGHT cursor", cursor_pos, 6'h01);
    chk("UP beats ENTER point", point_pos, 6'h00);
    step();
    chk("UP beats others number", number, 95);

    // UP wraps 9 to 0 on d1 without carry.
    press(5'b00100); press(5'b00001); press(5'b01000);
    step();
    chk("UP wrap no carry", number, 5);

    // Decimal point on d0 while d0 = 0.
    for (int i = 0; i < 5; i++) press(5'b00010);
    press(5'b10000);
    chk("ENTER sets point", point_pos, 6'h01);
    step();
    chk("number all zero", number, 0);
    wait_sel(6'h3E, ok);
    chk("d0 slot reached", ok, 1);
    chk("dig d0 with point", dig, 8'h40);
    press(5'b10000);
    chk("ENTER clears point", point_pos, 6'h00);
    for (int i = 0; i < 7; i++) press(5'b00001);
    step();
    chk("number 7", number, 7);
    wait_sel(6'h3E, ok);
    chk("d0 slot reached again", ok, 1);
    chk("dig d0 shows 7", dig, 8'hF8);

    // Asynchronous reset between edges, then clean restart.
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async rst sel", sel, 6'h3F);
    chk("async rst dig", dig, 8'hFF);
    chk("async rst number", number, 0);
    chk("async rst cursor", cursor_pos, 6'h01);
    chk("async rst time_ms", time_ms, 0);
    #2 rst = 1'b0;
    check_ticks(100);
    chk("restart time_ms", time_ms, 1);
    chk("restart sel", sel, 6'h3E);
    chk("restart dig", dig, 8'hC0);

    // Slow tick 7 shows d0 (cursor); with blinking it falls in a hidden phase.
    for (int i = 0; i < 6; i++) begin
      wait_tick(ok);
      chk("slow tick arrives", ok, 1);
    end
    chk("tick7 sel", sel, 6'h3E);
`ifdef DIGITRON_BLINK_EN
    chk("tick7 cursor digit hidden", dig, 8'hFF);
`else
    chk("tick7 cursor digit shown", dig, 8'hC0);
`endif
    // Moving the cursor onto d1 restarts a visible phase for tick 8.
    press(5'b00100);
    wait_tick(ok);
    chk("slow tick 8 arrives", ok, 1);
    chk("tick8 sel", sel, 6'h3D);
    chk("tick8 cursor digit visible", dig, 8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
